// File: rtl/fibo_datapath.sv
// Fibonacci engine datapath: 4-entry register file (1W/2R), 8-function ALU
// and a write-back mux selecting the external count or the ALU result.
module fibo_datapath #(
   parameter int unsigned size = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      wrt_addr,
   input  logic            wrt_en,
   input  logic            load_data,
   input  logic [1:0]      rd_addr1,
   input  logic [1:0]      rd_addr2,
   input  logic [2:0]      alu_opcode,
   input  logic [size-1:0] count,
   output logic            zero_flag,
   output logic [size-1:0] data
);

   localparam int unsigned NREGS = 4;

   typedef enum logic [2:0] {
      OP_PASS_A = 3'b000,
      OP_PASS_B = 3'b001,
      OP_SUB    = 3'b010,
      OP_AND    = 3'b011,
      OP_OR     = 3'b100,
      OP_XOR    = 3'b101,
      OP_ADD    = 3'b110,
      OP_INC    = 3'b111
   } alu_op_e;

   logic [size-1:0] rf_q [NREGS];
   logic [size-1:0] rf_d [NREGS];
   logic [size-1:0] opnd_a;
   logic [size-1:0] opnd_b;
   logic [size-1:0] alu_result;
   logic [size-1:0] wdata;

   // Combinational read ports; no bypass, so a write shows up after the edge.
   assign opnd_a = rf_q[rd_addr1];
   assign opnd_b = rf_q[rd_addr2];

   // ALU: all arithmetic wraps modulo 2^size.
   always_comb begin
      alu_result = '0;
      unique case (alu_op_e'(alu_opcode))
         OP_PASS_A: alu_result = opnd_a;
         OP_PASS_B: alu_result = opnd_b;
         OP_SUB:    alu_result = opnd_a - opnd_b;
         OP_AND:    alu_result = opnd_a & opnd_b;
         OP_OR:     alu_result = opnd_a | opnd_b;
         OP_XOR:    alu_result = opnd_a ^ opnd_b;
         OP_ADD:    alu_result = opnd_a + opnd_b;
         OP_INC:    alu_result = opnd_a + size'(1);
         default:   alu_result = '0;
      endcase
   end

   assign wdata     = load_data ? count : alu_result;
   assign data      = alu_result;
   assign zero_flag = (alu_result == '0);

   // Register file next state.
   always_comb begin
      rf_d = rf_q;
      if (wrt_en) begin
         rf_d[wrt_addr] = wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_q <= '{default: '0};
      end else begin
         rf_q <= rf_d;
      end
   end

endmodule

// File: tb/tb_fibo_datapath.sv
// Self-checking bench for fibo_datapath: directed test plan plus random
// traffic against an arithmetic reference model of the register file and ALU.
module tb_fibo_datapath;

   logic       clk;
   logic       rst_n;
   logic [1:0] wrt_addr;
   logic       wrt_en;
   logic       load_data;
   logic [1:0] rd_addr1;
   logic [1:0] rd_addr2;
   logic [2:0] alu_opcode;
   logic [3:0] count;
   logic       zero_flag;
   logic [3:0] data;

   int tests;
   int fails;
   int unsigned m [4];

   fibo_datapath #(.size(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt_addr   (wrt_addr),
      .wrt_en     (wrt_en),
      .load_data  (load_data),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .alu_opcode (alu_opcode),
      .count      (count),
      .zero_flag  (zero_flag),
      .data       (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned ref_alu(input int unsigned op, input int unsigned a,
                                           input int unsigned b);
      case (op)
         0: return a;
         1: return b;
         2: return (a + 16 - b) % 16;
         3: return a & b;
         4: return a | b;
         5: return a ^ b;
         6: return (a + b) % 16;
         default: return (a + 1) % 16;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive read side and compare data/zero_flag with the model.
   task automatic read_chk(input string tag, input int unsigned ra1, input int unsigned ra2,
                           input int unsigned op);
      int unsigned e;
      rd_addr1   = 2'(ra1);
      rd_addr2   = 2'(ra2);
      alu_opcode = 3'(op);
      #1;
      e = ref_alu(op, m[ra1], m[ra2]);
      check({tag, ".data"}, {28'b0, data}, e);
      check({tag, ".zf"}, {31'b0, zero_flag}, (e == 0) ? 1 : 0);
   endtask

   // One clocked write; ALU output is checked before the edge.
   task automatic wr(input string tag, input int unsigned wa, input bit en, input bit ld,
                     input int unsigned cnt, input int unsigned ra1, input int unsigned ra2,
                     input int unsigned op);
      int unsigned e;
      wrt_addr  = 2'(wa);
      wrt_en    = en;
      load_data = ld;
      count     = 4'(cnt);
      read_chk({tag, ".pre"}, ra1, ra2, op);
      e = ld ? cnt : ref_alu(op, m[ra1], m[ra2]);
      @(posedge clk);
      #1;
      if (en) m[wa] = e;
      wrt_en = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < 4; i++) m[i] = 0;
      rst_n = 1'b0; wrt_addr = '0; wrt_en = 1'b0; load_data = 1'b0;
      rd_addr1 = '0; rd_addr2 = '0; alu_opcode = '0; count = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: reset state
      read_chk("rst_add", 0, 0, 6);
      check("rst_add_const", {28'b0, data}, 0);
      read_chk("rst_inc", 0, 0, 7);
      check("rst_inc_const", {28'b0, data}, 1);

      // 2: load count=1 into all registers
      for (int i = 0; i < 4; i++) wr("load1", i, 1, 1, 1, 0, 0, 0);
      read_chk("r3_is_1", 3, 0, 0);

      // 3: Fibonacci steps
      wr("fib1", 1, 1, 0, 0, 0, 3, 6); read_chk("fib1_r1", 1, 1, 0);
      wr("fib2", 2, 1, 0, 0, 1, 0, 6); read_chk("fib2_r2", 2, 2, 0);
      wr("fib3", 3, 1, 0, 0, 2, 1, 6); read_chk("fib3_r3", 3, 3, 0);
      wr("fib4", 0, 1, 0, 0, 3, 2, 6); read_chk("fib4_r0", 0, 0, 0);
      check("fib4_const", {28'b0, data}, 8);
      wr("fib5", 1, 1, 0, 0, 0, 3, 6); read_chk("fib5_r1", 1, 1, 0);
      check("fib5_const", {28'b0, data}, 13);
      wr("fib6", 2, 1, 0, 0, 1, 0, 6); read_chk("fib6_r2", 2, 2, 0);
      wr("fib7", 3, 1, 0, 0, 2, 1, 6); read_chk("fib7_r3", 3, 3, 0);
      check("fib7_const", {28'b0, data}, 2);

      // 4: overflow to zero
      wr("ld8a", 0, 1, 1, 8, 0, 0, 0);
      wr("ld8b", 1, 1, 1, 8, 0, 0, 0);
      read_chk("ovf", 0, 1, 6);
      check("ovf_zf_const", {31'b0, zero_flag}, 1);
      wr("ovf_wr", 3, 1, 0, 0, 0, 1, 6);
      read_chk("ovf_r3", 3, 3, 0);

      // 5: write disabled leaves registers alone
      wr("ld5", 2, 1, 1, 5, 0, 0, 0);
      wr("noen", 2, 0, 1, 9, 0, 0, 0);
      read_chk("noen_r2", 2, 2, 0);
      check("noen_const", {28'b0, data}, 5);

      // 6: ALU ops on A=12, B=5 and wrapping subtract
      wr("ld12", 0, 1, 1, 12, 0, 0, 0);
      wr("ld5b", 1, 1, 1, 5, 0, 0, 0);
      for (int op = 0; op < 8; op++) read_chk($sformatf("op%0d", op), 0, 1, op);
      read_chk("sub_wrap", 1, 0, 2);
      check("sub_wrap_const", {28'b0, data}, 9);

      // Async reset between edges, held across an edge with a write pending
      wrt_addr = 2'd0; wrt_en = 1'b1; load_data = 1'b1; count = 4'd7;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) m[i] = 0;
      for (int i = 0; i < 4; i++) read_chk($sformatf("arst_r%0d", i), i, i, 0);
      @(posedge clk);
      #1;
      read_chk("arst_hold", 0, 0, 0);
      rst_n = 1'b1;
      wr("post_rst", 0, 1, 1, 7, 0, 0, 0);
      read_chk("post_rst_r0", 0, 0, 0);

      // Random traffic against the model
      for (int n = 0; n < 300; n++) begin
         wr("rnd", $urandom_range(3), 1'($urandom_range(1)), 1'($urandom_range(1)),
            $urandom_range(15), $urandom_range(3), $urandom_range(3), $urandom_range(7));
         if (n % 10 == 0) read_chk("rnd_rd", $urandom_range(3), $urandom_range(3),
                                   $urandom_range(7));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
